// File: rtl/spi_mem_loader.sv
// SPI slave (mode 0, MSB first) that writes and reads back the Nano system
// memory while the core is held in programming mode. The SPI pins are
// asynchronous to CLK: each one is brought in through a two-flop synchroniser,
// and SCK/CS edges are detected as single-cycle pulses.
// Frame format: command byte (0x02 write, 0x03 read), address byte, then data
// bytes. The address increments after every data byte.
module spi_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic              EN,
    input  logic              SPI_SCK,
    input  logic              SPI_MOSI,
    input  logic              SPI_CS,
    output logic              SPI_MISO,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    localparam logic [DATA_W-1:0] CMD_WRITE = DATA_W'(8'h02);
    localparam logic [DATA_W-1:0] CMD_READ  = DATA_W'(8'h03);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_sck_s1, r_sck_s2, r_sck_prev;
    logic                r_cs_s1, r_cs_s2, r_cs_prev;
    logic                r_mosi_s1, r_mosi_s2;

    logic [2:0]          r_bitcnt;
    logic [DATA_W-2:0]   r_shift;   // first seven bits of the byte being received
    logic [DATA_W-2:0]   r_tx;      // bits still to be sent on MISO
    logic                r_is_read;
    logic                r_miso;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic                r_busy;

    logic                w_sck_rise;
    logic                w_sck_fall;
    logic                w_cs_fall;
    logic                w_abort;
    logic                w_byte_done;
    logic [DATA_W-1:0]   w_byte;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_prev;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_prev;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_prev;
    // CS high or loader disabled ends any frame in the same cycle.
    assign w_abort     = r_cs_s2 | ~EN;
    assign w_byte      = {r_shift, r_mosi_s2};
    assign w_byte_done = w_sck_rise && (r_bitcnt == 3'd7) && (r_state != ST_IDLE);

    assign SPI_MISO  = r_miso;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign MEM_WE    = r_mem_we;
    assign BUSY      = r_busy;

    // Two-flop synchronisers plus the previous-value flops used for edge detection.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_prev <= 1'b0;
            r_cs_s1    <= 1'b1;
            r_cs_s2    <= 1'b1;
            r_cs_prev  <= 1'b1;
            r_mosi_s1  <= 1'b0;
            r_mosi_s2  <= 1'b0;
        end else begin
            r_sck_s1   <= SPI_SCK;
            r_sck_s2   <= r_sck_s1;
            r_sck_prev <= r_sck_s2;
            r_cs_s1    <= SPI_CS;
            r_cs_s2    <= r_cs_s1;
            r_cs_prev  <= r_cs_s2;
            r_mosi_s1  <= SPI_MOSI;
            r_mosi_s2  <= r_mosi_s1;
        end
    end

    // State register; BUSY follows whether the next state is inside a frame.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state logic: frame start on a CS fall, byte-driven progress afterwards.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) w_state_nxt = ST_CMD;
                end
                ST_CMD: begin
                    if (w_byte_done) begin
                        if (w_byte == CMD_WRITE || w_byte == CMD_READ) w_state_nxt = ST_ADDR;
                        else                                           w_state_nxt = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (w_byte_done) w_state_nxt = r_is_read ? ST_RDATA : ST_WDATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Bit receiver: shift MOSI on SCK rises; counter cleared whenever no frame is active.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_bitcnt  <= 3'd0;
            r_shift   <= '0;
            r_is_read <= 1'b0;
        end else if (w_abort || r_state == ST_IDLE) begin
            r_bitcnt <= 3'd0;
        end else if (w_sck_rise) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            r_shift  <= w_byte[DATA_W-2:0];
            if (r_state == ST_CMD && r_bitcnt == 3'd7) r_is_read <= (w_byte == CMD_READ);
        end
    end

    // Memory port: address load, one-cycle write strobe, post-word address increment.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            // A committed write moves the address on the cycle after the strobe.
            if (r_mem_we) r_mem_addr <= r_mem_addr + ADDR_W'(1);
            if (!w_abort && w_byte_done) begin
                case (r_state)
                    ST_ADDR:  r_mem_addr <= w_byte[ADDR_W-1:0];
                    ST_WDATA: begin
                        r_mem_wdata <= w_byte;
                        r_mem_we    <= 1'b1;
                    end
                    // Advance early so the next word is ready before the next SCK fall.
                    ST_RDATA: r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    default:  ;
                endcase
            end
        end
    end

    // MISO serialiser: load a fresh word at bit 0, otherwise shift, on SCK falls in RDATA.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_miso <= 1'b0;
            r_tx   <= '0;
        end else if (w_abort || r_state != ST_RDATA) begin
            r_miso <= 1'b0;
        end else if (w_sck_fall) begin
            if (r_bitcnt == 3'd0) begin
                r_miso <= MEM_RDATA[DATA_W-1];
                r_tx   <= MEM_RDATA[DATA_W-2:0];
            end else begin
                r_miso <= r_tx[DATA_W-2];
                r_tx   <= {r_tx[DATA_W-3:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Self-checking bench for spi_mem_loader: an SPI master drives frames, a small
// memory model answers reads, and expected writes/read bytes are queued on a
// scoreboard and compared as the DUT produces them.
module tb_spi_mem_loader;

    localparam int HALF = 5;  // CLK cycles per SCK phase

    logic       clk = 1'b0;
    logic       nrst, en, sck, mosi, cs;
    logic       miso, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;
    int we_count = 0;
    int we0;

    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [15:0] e_wr;
    logic [7:0]  rx;
    logic        miso_seen, busy_seen;

    always #5 clk = ~clk;

    spi_mem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK       (clk),
        .NRST      (nrst),
        .EN        (en),
        .SPI_SCK   (sck),
        .SPI_MOSI  (mosi),
        .SPI_CS    (cs),
        .SPI_MISO  (miso),
        .MEM_ADDR  (mem_addr),
        .MEM_WDATA (mem_wdata),
        .MEM_WE    (mem_we),
        .MEM_RDATA (mem_rdata),
        .BUSY      (busy)
    );

    // Memory model: synchronous write, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write monitor: every strobe must match the next queued (addr, data) pair.
    always @(negedge clk) begin
        if (miso) miso_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (nrst && mem_we) begin
            we_count++;
            if (exp_wr.size() == 0) begin
                check_eq("unexpected_we", 32'd1, 32'd0);
            end else begin
                e_wr = exp_wr.pop_front();
                check_eq("wr_addr", {24'd0, mem_addr}, {24'd0, e_wr[15:8]});
                check_eq("wr_data", {24'd0, mem_wdata}, {24'd0, e_wr[7:0]});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] r);
        r = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            r = {r[6:0], miso};
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic spi_send(input logic [7:0] tx);
        logic [7:0] dummy;
        spi_bits(tx, 8, dummy);
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        cs   = 1'b1;
        mosi = 1'b0;
        wait_clk(HALF + 3);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_miso"},  {31'd0, miso},      32'd0);
        check_eq({pfx, "_addr"},  {24'd0, mem_addr},  32'd0);
        check_eq({pfx, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check_eq({pfx, "_we"},    {31'd0, mem_we},    32'd0);
        check_eq({pfx, "_busy"},  {31'd0, busy},      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0; en = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        miso_seen = 1'b0; busy_seen = 1'b0;
        wait_clk(3);
        check_outputs_zero("reset");
        nrst = 1'b1;
        wait_clk(3);

        // Two-byte write frame with address increment.
        we0 = we_count;
        cs_begin();
        wait_clk(4);
        check_eq("busy_in_frame", {31'd0, busy}, 32'd1);
        spi_send(8'h02);
        spi_send(8'h10);
        exp_wr.push_back({8'h10, 8'hA5});
        spi_send(8'hA5);
        exp_wr.push_back({8'h11, 8'h3C});
        spi_send(8'h3C);
        cs_end();
        check_eq("s1_we_count", we_count - we0, 2);
        check_eq("s1_addr", {24'd0, mem_addr}, 32'h12);
        check_eq("s1_busy", {31'd0, busy}, 32'd0);
        check_eq("s1_pending", exp_wr.size(), 0);

        // Read back the two words.
        we0 = we_count;
        cs_begin();
        spi_send(8'h03);
        spi_send(8'h10);
        exp_rd.push_back(8'hA5);
        exp_rd.push_back(8'h3C);
        for (int k = 0; k < 2; k++) begin
            spi_bits(8'h00, 8, rx);
            check_eq("rd_byte", {24'd0, rx}, {24'd0, exp_rd.pop_front()});
        end
        cs_end();
        check_eq("s2_addr", {24'd0, mem_addr}, 32'h12);
        check_eq("s2_no_we", we_count - we0, 0);
        check_eq("s2_miso_idle", {31'd0, miso}, 32'd0);

        // Address wrap 0xFF -> 0x00.
        we0 = we_count;
        cs_begin();
        spi_send(8'h02);
        spi_send(8'hFF);
        exp_wr.push_back({8'hFF, 8'h11});
        spi_send(8'h11);
        exp_wr.push_back({8'h00, 8'h22});
        spi_send(8'h22);
        cs_end();
        check_eq("s3_we_count", we_count - we0, 2);
        check_eq("s3_addr", {24'd0, mem_addr}, 32'h01);

        // Partial byte aborted by CS, then a clean frame.
        we0 = we_count;
        cs_begin();
        spi_send(8'h02);
        spi_send(8'h20);
        spi_bits(8'hF0, 4, rx);
        cs_end();
        check_eq("s4_no_we", we_count - we0, 0);
        check_eq("s4_busy", {31'd0, busy}, 32'd0);
        cs_begin();
        spi_send(8'h02);
        spi_send(8'h20);
        exp_wr.push_back({8'h20, 8'h5A});
        spi_send(8'h5A);
        cs_end();
        check_eq("s4_we_count", we_count - we0, 1);
        check_eq("s4_addr", {24'd0, mem_addr}, 32'h21);

        // Unknown command is ignored; MISO stays low.
        we0 = we_count;
        miso_seen = 1'b0;
        cs_begin();
        spi_send(8'h55);
        spi_send(8'h30);
        spi_send(8'h77);
        cs_end();
        check_eq("s5_no_we", we_count - we0, 0);
        check_eq("s5_miso_quiet", {31'd0, miso_seen}, 32'd0);

        // Frame while disabled is ignored entirely.
        en = 1'b0;
        wait_clk(2);
        busy_seen = 1'b0;
        cs_begin();
        spi_send(8'h02);
        spi_send(8'h40);
        spi_send(8'h99);
        cs_end();
        check_eq("s5_en0_no_we", we_count - we0, 0);
        check_eq("s5_en0_busy", {31'd0, busy_seen}, 32'd0);
        en = 1'b1;
        wait_clk(3);

        // Reset mid data byte, then a fresh frame.
        we0 = we_count;
        cs_begin();
        spi_send(8'h02);
        spi_send(8'h50);
        spi_bits(8'hC3, 4, rx);
        check_eq("s6_busy_before", {31'd0, busy}, 32'd1);
        nrst = 1'b0;
        #1;
        check_outputs_zero("s6_rst");
        cs = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        wait_clk(3);
        nrst = 1'b1;
        wait_clk(3);
        check_eq("s6_no_we", we_count - we0, 0);
        cs_begin();
        spi_send(8'h02);
        spi_send(8'h50);
        exp_wr.push_back({8'h50, 8'h66});
        spi_send(8'h66);
        cs_end();
        check_eq("s6_we_count", we_count - we0, 1);
        check_eq("s6_addr", {24'd0, mem_addr}, 32'h51);

        check_eq("wr_queue_empty", exp_wr.size(), 0);
        check_eq("rd_queue_empty", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
